mostra_sequencia: RTL and testbench
===================================

MOSTRA_SEQUENCIA -- requirements
Module: mostra_sequencia

Interface
REQ-001 The module SHALL have parameter T_LIGADO, default 500, meaning LED on-time in clock cycles per entry in normal mode (even, >=2).
REQ-002 The module SHALL have parameter T_DESLIGADO, default 250, meaning LED off-time in clock cycles after each entry in normal mode (even, >=2).
REQ-003 The module SHALL have port clock  input  1  system clock, all state on rising edge.
REQ-004 The module SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 The module SHALL have port iniciar  input  1  start playback request, sampled only in OCIOSO.
REQ-006 The module SHALL have port abortar  input  1  synchronous cancel of playback.
REQ-007 The module SHALL have port dificuldade  input  1  1 = fast mode (both times halved), sampled at start.
REQ-008 The module SHALL have port tamanho  input  4  index of last entry to show (0..15), sampled at start.
REQ-009 The module SHALL have port dado_memoria  input  8  sequence memory read data, valid one cycle after endereco.
REQ-010 The module SHALL have port endereco  output  4  sequence memory read address.
REQ-011 The module SHALL have port leds  output  8  board LEDs, one-hot while showing an entry, else 0.
REQ-012 The module SHALL have port ocupado  output  1  high from first cycle after accepted start until return to OCIOSO.
REQ-013 The module SHALL have port pronto  output  1  one-cycle pulse when full sequence shown.
REQ-014 The module SHALL have port erro_dado  output  1  sticky flag: a fetched entry was not one-hot; cleared on next accepted start.
REQ-015 The module SHALL have port db_estado  output  4  current state code for the hexa7seg debug display.

Function
REQ-016 States SHALL be OCIOSO=0, BUSCA=1, LIGADO=2, DESLIGADO=3, FIM=4; all outputs registered.
REQ-017 OCIOSO with iniciar=1 and abortar=0 SHALL go to BUSCA, set endereco=0, latch tamanho and dificuldade, clear erro_dado.
REQ-018 BUSCA SHALL last exactly 1 cycle, then go to LIGADO loading leds with dado_memoria.
REQ-019 A non-one-hot dado_memoria in BUSCA SHALL set erro_dado and load leds with 0 for that entry; timing is unchanged.
REQ-020 LIGADO SHALL last TL cycles, then clear leds and go to DESLIGADO; TL = T_LIGADO, or T_LIGADO/2 if latched dificuldade=1.
REQ-021 DESLIGADO SHALL last TD cycles (T_DESLIGADO, or T_DESLIGADO/2 if fast), then go to FIM if endereco equals latched tamanho, else increment endereco and go to BUSCA.
REQ-022 FIM SHALL assert pronto for exactly 1 cycle, then return to OCIOSO; endereco SHALL hold its last value.
REQ-023 Per-entry duration SHALL be 1+TL+TD cycles; an N-entry playback SHALL keep ocupado high N*(1+TL+TD)+1 cycles, including FIM.
REQ-024 iniciar SHALL be ignored outside OCIOSO; tamanho and dificuldade changes mid-playback SHALL have no effect.
REQ-025 abortar=1 in any state other than OCIOSO SHALL return to OCIOSO next cycle with leds=0, ocupado=0 and no pronto pulse.
REQ-026 abortar and iniciar both high in OCIOSO SHALL leave the block in OCIOSO (abortar wins).
REQ-027 endereco SHALL never exceed latched tamanho; no wrap-around occurs since tamanho=15 ends at address 15.

Reset
REQ-028 reset=0 SHALL asynchronously force OCIOSO, endereco=0, leds=0, ocupado=0, pronto=0, erro_dado=0 and the timer to 0, including mid-playback.
REQ-029 After reset release, the first iniciar SHALL be accepted on the first rising edge where reset=1.

Structure
REQ-030 Package geogenius_pkg SHALL hold the state encoding, LED width 8, address width 4 and default timing constants.
REQ-031 Timing SHALL use one sub-module, contador_temporizador: a loadable down-counter with a fim flag, reused for both TL and TD.

Verification
REQ-032 Set T_LIGADO=4, T_DESLIGADO=2, tamanho=0, mem[0]=8'h04, pulse iniciar -> leds=8'h04 for 4 cycles, 0 for 2 cycles, then pronto for 1 cycle; ocupado high 8 cycles.
REQ-033 Set tamanho=2, mem=01,10,80, dificuldade=1 -> each entry shown 2 cycles with 1 off cycle; endereco steps 0,1,2; pronto 13 cycles after start.
REQ-034 Set mem[1]=8'h03, tamanho=1 -> erro_dado rises at fetch of entry 1, leds stay 0 for that slot, pronto still pulses; next iniciar clears erro_dado.
REQ-035 Assert abortar during second LIGADO -> next cycle leds=0, ocupado=0, no pronto; iniciar held high mid-playback is ignored.
REQ-036 Drive reset low mid-DESLIGADO -> all outputs 0 immediately without a clock edge; iniciar with abortar both high in OCIOSO -> stays OCIOSO.

Source files
------------

// File: rtl/geogenius_pkg.sv
// geogenius_pkg: shared state encoding, widths, default timing and one-hot check
// for the sequence display block.
package geogenius_pkg;
    localparam int LED_W = 8;
    localparam int END_W = 4;
    localparam int T_LIGADO_PADRAO = 500;
    localparam int T_DESLIGADO_PADRAO = 250;
    typedef enum logic [3:0] {
        OCIOSO    = 4'd0,
        BUSCA     = 4'd1,
        LIGADO    = 4'd2,
        DESLIGADO = 4'd3,
        FIM       = 4'd4
    } estado_t;
    function automatic logic um_quente(input logic [LED_W-1:0] d);
        return (d != '0) && ((d & (d - LED_W'(1))) == '0);
    endfunction
endpackage

// File: rtl/contador_temporizador.sv
// contador_temporizador: loadable down-counter that parks at zero and flags it with fim.
module contador_temporizador #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         carregar,
    input  logic [W-1:0] valor,
    output logic         fim
);
    logic [W-1:0] q;
    always_ff @(posedge clock or negedge reset)
        if (!reset) q <= '0;
        else if (carregar) q <= valor;
        else if (q != '0) q <= q - W'(1);
    assign fim = (q == '0);
endmodule

// File: rtl/mostra_sequencia.sv
// mostra_sequencia: plays back entries 0..tamanho of the sequence memory on the LEDs,
// each entry as one fetch cycle, an on-phase and an off-phase.
module mostra_sequencia
    import geogenius_pkg::*;
#(
    parameter int T_LIGADO    = T_LIGADO_PADRAO,
    parameter int T_DESLIGADO = T_DESLIGADO_PADRAO
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             iniciar,
    input  logic             abortar,
    input  logic             dificuldade,
    input  logic [END_W-1:0] tamanho,
    input  logic [LED_W-1:0] dado_memoria,
    output logic [END_W-1:0] endereco,
    output logic [LED_W-1:0] leds,
    output logic             ocupado,
    output logic             pronto,
    output logic             erro_dado,
    output logic [3:0]       db_estado
);
    localparam int TMAX = T_LIGADO > T_DESLIGADO ? T_LIGADO : T_DESLIGADO;
    localparam int CW = $clog2(TMAX) + 1;
    // Counter is loaded with duration-1 so the phase lasts exactly duration cycles.
    localparam logic [CW-1:0] TLN = CW'(T_LIGADO - 1);
    localparam logic [CW-1:0] TLR = CW'(T_LIGADO / 2 - 1);
    localparam logic [CW-1:0] TDN = CW'(T_DESLIGADO - 1);
    localparam logic [CW-1:0] TDR = CW'(T_DESLIGADO / 2 - 1);

    estado_t          estado;
    logic [END_W-1:0] tamanho_r;
    logic             rapido;
    logic             fim;
    logic             carregar;
    logic [CW-1:0]    valor;

    assign carregar = (estado == BUSCA) || (estado == LIGADO && fim);
    assign valor = (estado == BUSCA) ? (rapido ? TLR : TLN) : (rapido ? TDR : TDN);
    assign db_estado = estado;

    contador_temporizador #(.W(CW)) u_temporizador (
        .clock    (clock),
        .reset    (reset),
        .carregar (carregar),
        .valor    (valor),
        .fim      (fim)
    );

    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            estado    <= OCIOSO;
            endereco  <= '0;
            leds      <= '0;
            ocupado   <= 1'b0;
            pronto    <= 1'b0;
            erro_dado <= 1'b0;
            tamanho_r <= '0;
            rapido    <= 1'b0;
        end else if (abortar && estado != OCIOSO) begin
            estado  <= OCIOSO;
            leds    <= '0;
            ocupado <= 1'b0;
            pronto  <= 1'b0;
        end else
            case (estado)
                OCIOSO: begin
                    pronto <= 1'b0;
                    if (iniciar && !abortar) begin
                        estado    <= BUSCA;
                        endereco  <= '0;
                        tamanho_r <= tamanho;
                        rapido    <= dificuldade;
                        erro_dado <= 1'b0;
                        ocupado   <= 1'b1;
                    end
                end
                BUSCA: begin
                    estado <= LIGADO;
                    leds   <= um_quente(dado_memoria) ? dado_memoria : '0;
                    if (!um_quente(dado_memoria)) erro_dado <= 1'b1;
                end
                LIGADO:
                    if (fim) begin
                        estado <= DESLIGADO;
                        leds   <= '0;
                    end
                DESLIGADO:
                    if (fim) begin
                        if (endereco == tamanho_r) begin
                            estado <= FIM;
                            pronto <= 1'b1;
                        end else begin
                            estado   <= BUSCA;
                            endereco <= endereco + END_W'(1);
                        end
                    end
                FIM: begin
                    estado  <= OCIOSO;
                    pronto  <= 1'b0;
                    ocupado <= 1'b0;
                end
                default: estado <= OCIOSO;
            endcase
endmodule

// File: tb/tb_mostra_sequencia.sv
// tb_mostra_sequencia: directed and randomized playbacks compared cycle by cycle
// against a trace built from the entry timing rules.
module tb_mostra_sequencia;
    localparam int TL = 4;
    localparam int TD = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       iniciar = 1'b0;
    logic       abortar = 1'b0;
    logic       dificuldade = 1'b0;
    logic [3:0] tamanho = '0;
    logic [7:0] dado_memoria;
    logic [3:0] endereco;
    logic [7:0] leds;
    logic       ocupado;
    logic       pronto;
    logic       erro_dado;
    logic [3:0] db_estado;
    logic [7:0] mem [16];

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;
    assign dado_memoria = mem[endereco];

    mostra_sequencia #(.T_LIGADO(TL), .T_DESLIGADO(TD)) dut (
        .clock        (clock),
        .reset        (reset),
        .iniciar      (iniciar),
        .abortar      (abortar),
        .dificuldade  (dificuldade),
        .tamanho      (tamanho),
        .dado_memoria (dado_memoria),
        .endereco     (endereco),
        .leds         (leds),
        .ocupado      (ocupado),
        .pronto       (pronto),
        .erro_dado    (erro_dado),
        .db_estado    (db_estado)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] e_end, input logic [7:0] e_leds,
                           input logic e_oc, input logic e_pr, input logic e_err, input logic [3:0] e_db);
        chk({tag, ".endereco"}, 32'(endereco), 32'(e_end));
        chk({tag, ".leds"}, 32'(leds), 32'(e_leds));
        chk({tag, ".ocupado"}, 32'(ocupado), 32'(e_oc));
        chk({tag, ".pronto"}, 32'(pronto), 32'(e_pr));
        chk({tag, ".erro_dado"}, 32'(erro_dado), 32'(e_err));
        chk({tag, ".db_estado"}, 32'(db_estado), 32'(e_db));
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Expected trace: entry i = 1 fetch cycle + tl on-cycles + td off-cycles, then one FIM cycle.
    task automatic play(input string tag, input int last, input bit fast, input int abort_at, input int rst_at);
        int tl = fast ? TL / 2 : TL;
        int td = fast ? TD / 2 : TD;
        int s = 0;
        bit err = 0;
        iniciar = 1'b1;
        dificuldade = fast;
        tamanho = 4'(last);
        step();
        for (int i = 0; i <= last; i++) begin
            bit bad = ($countones(mem[i]) != 1);
            for (int c = 0; c < 1 + tl + td; c++) begin
                logic [7:0] el;
                logic [3:0] db;
                if (c == 1 && bad) err = 1;
                el = (c >= 1 && c <= tl && !bad) ? mem[i] : 8'h00;
                db = (c == 0) ? 4'd1 : (c <= tl) ? 4'd2 : 4'd3;
                chk_out(tag, 4'(i), el, 1'b1, 1'b0, err, db);
                if (s == rst_at) begin
                    iniciar = 1'b0;
                    reset = 1'b0;
                    #1;
                    chk_out({tag, ".async_reset"}, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
                    #1 reset = 1'b1;
                    return;
                end
                if (s == abort_at) begin
                    abortar = 1'b1;
                    iniciar = 1'b0;
                    step();
                    abortar = 1'b0;
                    chk({tag, ".abort.leds"}, 32'(leds), 32'h0);
                    chk({tag, ".abort.ocupado"}, 32'(ocupado), 32'h0);
                    chk({tag, ".abort.pronto"}, 32'(pronto), 32'h0);
                    chk({tag, ".abort.db_estado"}, 32'(db_estado), 32'h0);
                    step();
                    chk({tag, ".abort.idle_pronto"}, 32'(pronto), 32'h0);
                    chk({tag, ".abort.idle_ocupado"}, 32'(ocupado), 32'h0);
                    return;
                end
                iniciar = 1'($urandom);
                tamanho = 4'($urandom);
                dificuldade = 1'($urandom);
                step();
                s++;
            end
        end
        iniciar = 1'b0;
        chk_out({tag, ".fim"}, 4'(last), 8'h00, 1'b1, 1'b1, err, 4'd4);
        step();
        chk_out({tag, ".idle"}, 4'(last), 8'h00, 1'b0, 1'b0, err, 4'd0);
    endtask

    initial begin
        for (int j = 0; j < 16; j++) mem[j] = 8'h00;
        #2;
        chk_out("reset_async", 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
        #11;
        chk_out("reset_held", 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
        reset = 1'b1;

        mem[0] = 8'h04;
        play("single", 0, 1'b0, -1, -1);

        mem[0] = 8'h01; mem[1] = 8'h10; mem[2] = 8'h80;
        play("fast3", 2, 1'b1, -1, -1);

        mem[0] = 8'h01; mem[1] = 8'h03;
        play("bad_entry", 1, 1'b0, -1, -1);
        mem[0] = 8'h02;
        play("err_clear", 0, 1'b0, -1, -1);

        mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h04;
        play("abort", 2, 1'b0, (1 + TL + TD) + 2, -1);

        play("rst_mid", 1, 1'b0, -1, 1 + TL);

        iniciar = 1'b1;
        abortar = 1'b1;
        step();
        chk("both_high.ocupado", 32'(ocupado), 32'h0);
        chk("both_high.db_estado", 32'(db_estado), 32'h0);
        step();
        chk("both_high2.db_estado", 32'(db_estado), 32'h0);
        iniciar = 1'b0;
        abortar = 1'b0;
        step();

        mem[0] = 8'h08;
        play("after_both", 0, 1'b1, -1, -1);

        for (int r = 0; r < 8; r++) begin
            int last = $urandom_range(0, 15);
            int ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : -1;
            for (int j = 0; j < 16; j++)
                mem[j] = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'(1 << $urandom_range(0, 7));
            play("random", last, 1'($urandom), ab, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
